// File: rtl/fetch_decode_stage_pkg.sv
// fetch_decode_stage_pkg: RV32I opcode constants, NOP encoding and immediate-format classification
package fetch_decode_stage_pkg;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    function automatic imm_type_e imm_type(input logic [6:0] opc);
        return (opc == OPC_LOAD || opc == OPC_ARI_ITYPE || opc == OPC_JALR) ? IMM_I :
               opc == OPC_STORE ? IMM_S :
               opc == OPC_BRANCH ? IMM_B :
               (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
               opc == OPC_JAL ? IMM_J : IMM_NONE;
    endfunction
endpackage

// File: rtl/fetch_decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator, sign-extended from inst[31]
module imm_gen (
    input  logic [31:0] inst,
    output logic [31:0] imm
);
    import fetch_decode_stage_pkg::*;
    imm_type_e t;
    always_comb begin
        t = imm_type(inst[6:0]);
        imm = t == IMM_I ? {{20{inst[31]}}, inst[31:20]} :
              t == IMM_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              t == IMM_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              t == IMM_U ? {inst[31:12], 12'b0} :
              t == IMM_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              32'b0;
    end
endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC/fetch front end with redirect squash, stall skid buffer and decode
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = fetch_decode_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        x_pcsel,
    input  logic [31:0] x_target,
    output logic [31:0] imem_addr,
    output logic        imem_re,
    input  logic [31:0] imem_dout,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc,
    output logic        d_valid,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [4:0]  d_rd,
    output logic [31:0] d_imm
);
    import fetch_decode_stage_pkg::*;
    logic [31:0] pc_q, hold_inst_q, next_pc, raw_inst;
    logic        valid_q, hold_q;
    imm_type_e   t;
    always_comb begin
        next_pc = stall ? pc_q : x_pcsel ? x_target : pc_q + 32'd4;
        imem_addr = rst_n ? next_pc : RESET_PC;
        imem_re = 1'b1;
        // during a stall imem output is not trustworthy; the skid copy is
        raw_inst = hold_q ? hold_inst_q : imem_dout;
        d_valid = valid_q & ~x_pcsel & rst_n;
        d_inst = d_valid ? raw_inst : NOP_INST;
        d_pc = pc_q;
        t = imm_type(d_inst[6:0]);
        d_rs1 = (d_valid && t != IMM_U && t != IMM_J) ? d_inst[19:15] : 5'd0;
        d_rs2 = (d_valid && (t == IMM_S || t == IMM_B || t == IMM_NONE)) ? d_inst[24:20] : 5'd0;
        d_rd = (d_valid && t != IMM_S && t != IMM_B) ? d_inst[11:7] : 5'd0;
    end
    imm_gen u_imm (.inst(d_inst), .imm(d_imm));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC - 32'd4;
            valid_q <= 1'b0;
            hold_q <= 1'b0;
        end else if (stall) begin
            if (!hold_q) begin
                hold_inst_q <= imem_dout;
                hold_q <= 1'b1;
            end
        end else begin
            pc_q <= next_pc;
            valid_q <= 1'b1;
            hold_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: table-driven directed checks of fetch, redirect, stall skid and decode
module tb_fetch_decode_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
    localparam logic [31:0] JAL  = 32'h0010_00EF;
    localparam logic [31:0] SW   = 32'h0053_2623;
    localparam logic [31:0] LUI  = 32'hABCD_E2B7;
    localparam logic [31:0] A2010 = 32'h0100_0113;
    localparam logic [31:0] A3004 = 32'h0040_0113;

    logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, x_pcsel = 1'b0, scr = 1'b0;
    logic [31:0] x_target = '0, imem_addr, imem_dout, rdata_q = '0, scr_val = '0;
    logic [31:0] d_inst, d_pc, d_imm;
    logic imem_re, d_valid;
    logic [4:0] d_rs1, d_rs2, d_rd;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .x_pcsel(x_pcsel), .x_target(x_target),
        .imem_addr(imem_addr), .imem_re(imem_re), .imem_dout(imem_dout),
        .d_inst(d_inst), .d_pc(d_pc), .d_valid(d_valid),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_imm(d_imm)
    );

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        case (a)
            32'h2000: return ADDI;
            32'h2004: return ADD;
            32'h200C: return SW;
            32'h2100: return BEQ;
            32'h2104: return JAL;
            32'h3000: return LUI;
            default:  return {a[11:0], 5'd0, 3'd0, 5'd2, 7'h13};
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_re) rdata_q <= mem_at(imem_addr);
        scr_val <= $urandom;
    end
    assign imem_dout = scr ? scr_val : rdata_q;

    typedef struct {
        logic rst, stl, sel, scr;
        logic [31:0] tgt, addr, pc;
        logic valid;
        logic [31:0] inst;
        logic [4:0] rs1, rs2, rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic rst, stl, sel, sc, input logic [31:0] tgt, addr, pc,
                                input logic valid, input logic [31:0] inst,
                                input logic [4:0] rs1, rs2, rd, input logic [31:0] imm);
        vec_t v;
        v.rst = rst; v.stl = stl; v.sel = sel; v.scr = sc; v.tgt = tgt; v.addr = addr; v.pc = pc;
        v.valid = valid; v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    initial begin
        vt[0]  = mk(1,0,0,0, 0,        32'h2000, 32'h1FFC, 0, NOP,   0,0,0, 0);
        vt[1]  = mk(1,0,0,0, 0,        32'h2004, 32'h2000, 1, ADDI,  0,0,1, 5);
        vt[2]  = mk(1,0,0,0, 0,        32'h2008, 32'h2004, 1, ADD,   1,2,3, 0);
        vt[3]  = mk(1,0,1,0, 32'h2100, 32'h2100, 32'h2008, 0, NOP,   0,0,0, 0);
        vt[4]  = mk(1,0,0,0, 0,        32'h2104, 32'h2100, 1, BEQ,   0,0,0, 32'hFFFF_FFF8);
        vt[5]  = mk(1,0,0,0, 0,        32'h2108, 32'h2104, 1, JAL,   0,0,1, 32'h800);
        vt[6]  = mk(1,0,1,0, 32'h200C, 32'h200C, 32'h2108, 0, NOP,   0,0,0, 0);
        vt[7]  = mk(1,1,0,0, 0,        32'h200C, 32'h200C, 1, SW,    6,5,0, 12);
        vt[8]  = mk(1,1,0,1, 0,        32'h200C, 32'h200C, 1, SW,    6,5,0, 12);
        vt[9]  = mk(1,1,0,1, 0,        32'h200C, 32'h200C, 1, SW,    6,5,0, 12);
        vt[10] = mk(1,0,0,1, 0,        32'h2010, 32'h200C, 1, SW,    6,5,0, 12);
        vt[11] = mk(1,0,0,0, 0,        32'h2014, 32'h2010, 1, A2010, 0,0,2, 16);
        vt[12] = mk(1,1,1,0, 32'h3000, 32'h2014, 32'h2014, 0, NOP,   0,0,0, 0);
        vt[13] = mk(1,1,1,1, 32'h3000, 32'h2014, 32'h2014, 0, NOP,   0,0,0, 0);
        vt[14] = mk(1,0,1,1, 32'h3000, 32'h3000, 32'h2014, 0, NOP,   0,0,0, 0);
        vt[15] = mk(1,0,0,0, 0,        32'h3004, 32'h3000, 1, LUI,   0,0,5, 32'hABCD_E000);
        vt[16] = mk(1,1,0,0, 0,        32'h3004, 32'h3004, 1, A3004, 0,0,2, 4);
        vt[17] = mk(1,1,0,1, 0,        32'h3004, 32'h3004, 1, A3004, 0,0,2, 4);
        vt[18] = mk(0,1,0,1, 0,        32'h2000, 32'h3004, 0, NOP,   0,0,0, 0);
        vt[19] = mk(1,0,0,0, 0,        32'h2000, 32'h1FFC, 0, NOP,   0,0,0, 0);
        vt[20] = mk(1,0,0,0, 0,        32'h2004, 32'h2000, 1, ADDI,  0,0,1, 5);
        vt[21] = mk(1,0,0,0, 0,        32'h2008, 32'h2004, 1, ADD,   1,2,3, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst d_valid", {31'b0, d_valid}, 0);
        chk("rst d_inst", d_inst, NOP);
        chk("rst d_pc", d_pc, 32'h1FFC);
        chk("rst imem_addr", imem_addr, 32'h2000);
        chk("rst imem_re", {31'b0, imem_re}, 1);
        chk("rst d_imm", d_imm, 0);
        chk("rst d_rd", {27'b0, d_rd}, 0);

        for (int i = 0; i < 22; i++) begin
            rst_n = vt[i].rst; stall = vt[i].stl; x_pcsel = vt[i].sel;
            scr = vt[i].scr; x_target = vt[i].tgt;
            #3;
            chk($sformatf("c%0d imem_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("c%0d d_pc", i), d_pc, vt[i].pc);
            chk($sformatf("c%0d d_valid", i), {31'b0, d_valid}, {31'b0, vt[i].valid});
            chk($sformatf("c%0d d_inst", i), d_inst, vt[i].inst);
            chk($sformatf("c%0d d_rs1", i), {27'b0, d_rs1}, {27'b0, vt[i].rs1});
            chk($sformatf("c%0d d_rs2", i), {27'b0, d_rs2}, {27'b0, vt[i].rs2});
            chk($sformatf("c%0d d_rd", i), {27'b0, d_rd}, {27'b0, vt[i].rd});
            chk($sformatf("c%0d d_imm", i), d_imm, vt[i].imm);
            @(posedge clk);
            #1;
        end

        x_pcsel = 1'b1; x_target = 32'hFFFF_FFFC; stall = 1'b0; scr = 1'b0; rst_n = 1'b1;
        #3;
        chk("wrap redirect addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap redirect squash", {31'b0, d_valid}, 0);
        @(posedge clk);
        #1;
        x_pcsel = 1'b0;
        #3;
        chk("wrap d_pc", d_pc, 32'hFFFF_FFFC);
        chk("wrap imem_addr", imem_addr, 32'h0);
        chk("wrap d_valid", {31'b0, d_valid}, 1);
        chk("wrap d_imm", d_imm, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        #3;
        chk("after wrap d_pc", d_pc, 32'h0);
        chk("after wrap imem_addr", imem_addr, 32'h4);
        chk("after wrap d_inst", d_inst, 32'h0000_0113);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
